network_tx_retry_buffer: RTL

- Sits directly downstream of the ASP output stage, on the network side.
- Captures each tagged frame the ASP emits (network_data_ready_out / network_data_tag_out) into a small FIFO.
- Transmits frames to the link one at a time and holds each frame until the far end acknowledges it.
- Retransmits on ACK timeout and drops a frame after a bounded number of retries, so the ASP never stalls on a lossy link.

---
 rtl/network_tx_retry_buffer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/network_tx_retry_buffer.sv
// Transmit retry buffer: queues tagged frames from the ASP and sends
// them to the link one at a time, retrying on ACK timeout, then dropping.
module network_tx_retry_buffer #(
  parameter int data_size   = 32,
  parameter int tag_size    = 8,
  parameter int depth       = 4,
  parameter int timeout     = 16,
  parameter int max_retries = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 frame_valid_in,
  input  logic [data_size+tag_size-1:0]        frame_in,
  input  logic                                 link_ACK_in,
  output logic                                 tx_valid_out,
  output logic [data_size+tag_size-1:0]        tx_frame_out,
  output logic                                 full_out,
  output logic                                 overflow_out,
  output logic                                 drop_out,
  output logic [$clog2(max_retries+1)-1:0]     retry_count_out,
  output logic [$clog2(depth):0]               occupancy_out
);

  localparam int FW = data_size + tag_size;
  localparam int PW = $clog2(depth);
  localparam int OW = PW + 1;
  localparam int RW = $clog2(max_retries + 1);
  localparam int TW = $clog2(timeout);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    DROP
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [FW-1:0] mem [depth];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_next;
  logic [OW-1:0] occ;
  logic [OW-1:0] occ_next;
  logic [TW-1:0] timer;
  logic [RW-1:0] retries;
  logic [FW-1:0] head_next;

  logic full;
  logic push;
  logic pop;
  logic ack;
  logic timer_done;
  logic retry_max;

  logic          tx_valid_d;
  logic          drop_d;
  logic          overflow_d;
  logic          full_d;
  logic [FW-1:0] frame_d;

  // Full is judged on the current count, so a pop in the same cycle
  // cannot make room for a push.
  assign full       = (occ == OW'(depth));
  assign push       = frame_valid_in && !full;
  assign ack        = (state == WAIT_ACK) && link_ACK_in;
  assign pop        = ack || (state == DROP);
  assign timer_done = (timer == TW'(timeout - 1));
  assign retry_max  = (retries == RW'(max_retries));

  // Next occupancy, read pointer and the frame that will be at the head.
  always_comb begin
    occ_next = occ;
    unique case ({push, pop})
      2'b10:   occ_next = occ + OW'(1);
      2'b01:   occ_next = occ - OW'(1);
      default: occ_next = occ;
    endcase
    rd_next = pop ? rd_ptr + PW'(1) : rd_ptr;
    if (push && (wr_ptr == rd_next)) begin
      head_next = frame_in;
    end else begin
      head_next = mem[rd_next];
    end
  end

  // Frame storage; contents need no reset since occupancy gates them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= frame_in;
    end
  end

  // FIFO pointers and entry count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_next;
      occ    <= occ_next;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; an ACK beats a coincident timeout.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (occ != '0) begin
          state_next = SEND;
        end
      end
      SEND: state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (link_ACK_in) begin
          state_next = IDLE;
        end else if (timer_done) begin
          state_next = retry_max ? DROP : SEND;
        end
      end
      DROP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ACK wait timer and per-frame retransmission counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer   <= '0;
      retries <= '0;
    end else begin
      if (state == SEND) begin
        timer <= '0;
      end else if ((state == WAIT_ACK) && !link_ACK_in && !timer_done) begin
        timer <= timer + TW'(1);
      end
      if (pop) begin
        retries <= '0;
      end else if ((state == WAIT_ACK) && !link_ACK_in && timer_done
                   && !retry_max) begin
        retries <= retries + RW'(1);
      end
    end
  end

  // Output decode from state and FIFO flags, fed to the output registers.
  always_comb begin
    tx_valid_d = (state == SEND);
    drop_d     = (state == DROP);
    overflow_d = frame_valid_in && full;
    full_d     = (occ_next == OW'(depth));
    frame_d    = (occ_next != '0) ? head_next : '0;
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_valid_out <= 1'b0;
      drop_out     <= 1'b0;
      overflow_out <= 1'b0;
      full_out     <= 1'b0;
      tx_frame_out <= '0;
    end else begin
      tx_valid_out <= tx_valid_d;
      drop_out     <= drop_d;
      overflow_out <= overflow_d;
      full_out     <= full_d;
      tx_frame_out <= frame_d;
    end
  end

  assign retry_count_out = retries;
  assign occupancy_out   = occ;

endmodule
